// File: rtl/mux_byte_skid_stage.sv
// Two-entry skid register behind the 8-bit byte mux; 1-cycle latency when empty, full throughput.
// in_ready drops only once both entries hold data. MUX_SKID_PARITY_EN adds a stored out_parity bit.
module mux_byte_skid_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
`ifdef MUX_SKID_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Each entry carries the tag (and parity when enabled) so they can never separate from the byte.
`ifdef MUX_SKID_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    in_pld;
  logic             accept;
  logic             emit;

`ifdef MUX_SKID_PARITY_EN
  assign in_pld = {^in_data, in_sel, in_data};
`else
  assign in_pld = {in_sel, in_data};
`endif

  assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_HALF);
  assign out_valid = (state_q == ST_HALF) || (state_q == ST_FULL);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = emit ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_HALF;
          main_d  = in_pld;
        end
      end
      ST_HALF: begin
        if (accept && !emit) begin
          state_d = ST_FULL;
          skid_d  = in_pld;
        end else if (emit && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && emit) begin
          main_d = in_pld;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_d = ST_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data = main_q[WIDTH-1:0];
  assign out_sel  = main_q[WIDTH];
  assign xfer_cnt = cnt_q;
`ifdef MUX_SKID_PARITY_EN
  assign out_parity = main_q[WIDTH+1];
`endif

endmodule

// File: tb/tb_mux_byte_skid_stage.sv
// Directed bench for mux_byte_skid_stage with a FIFO scoreboard on the output handshake.
module tb_mux_byte_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_ready;
  logic [7:0] xfer_cnt;
`ifdef MUX_SKID_PARITY_EN
  logic       out_parity;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] sb[$];
  logic       hold;
  logic [8:0] held;

  mux_byte_skid_stage #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
`ifdef MUX_SKID_PARITY_EN
    .out_parity(out_parity),
`endif
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) chk("stable", {23'd0, out_sel, out_data}, {23'd0, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("emit_unexpected", 32'd1, 32'd0);
        else chk("order", {23'd0, out_sel, out_data}, {23'd0, sb.pop_front()});
      end
      if (in_valid && in_ready) sb.push_back({in_sel, in_data});
      hold = out_valid && !out_ready;
      held = {out_sel, out_data};
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Single beat
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_sel", out_sel, 1);
    cyc();
    chk("single_empty", out_valid, 0);
    chk("single_cnt", xfer_cnt, 1);

    // Backpressure fills both entries; the third offer must be ignored
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b0;
    cyc();
    chk("bp_ready_half", in_ready, 1);
    in_data = 8'h22; in_sel = 1'b1;
    cyc();
    chk("bp_ready_full", in_ready, 0);
    chk("bp_head", out_data, 8'h11);
    in_data = 8'h33; in_sel = 1'b0;
    cyc();
    chk("bp_hold", out_data, 8'h11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_second", out_data, 8'h22);
    chk("bp_second_sel", out_sel, 1);
    cyc();
    chk("bp_drained", out_valid, 0);
    chk("bp_cnt", xfer_cnt, 3);

    // Accept and emit together while HALF
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h40; in_sel = 1'b0;
    cyc();
    in_data = 8'h41; in_sel = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("sim_data", out_data, 8'h41);
    chk("sim_valid", out_valid, 1);
    chk("sim_ready", in_ready, 1);
    cyc();
    chk("sim_cnt", xfer_cnt, 5);

    // Asynchronous reset with a beat in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; in_sel = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_data", out_data, 0);
    chk("ar_sel", out_sel, 0);
    chk("ar_cnt", xfer_cnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Streaming: one beat per cycle, counter wraps
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = i[7:0]; in_sel = i[0];
      cyc();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i & 8'hFF);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_cnt", xfer_cnt, 44);
    chk("stream_empty", out_valid, 0);

`ifdef MUX_SKID_PARITY_EN
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h07; in_sel = 1'b0;
    cyc();
    chk("par_07", out_parity, 1);
    in_data = 8'h03;
    cyc();
    in_valid = 1'b0;
    chk("par_hold", out_parity, 1);
    cyc();
    chk("par_hold2", out_parity, 1);
    out_ready = 1'b1;
    cyc();
    chk("par_03", out_parity, 0);
    cyc();
`endif

    cyc(); cyc();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
